// File: rtl/csa_seq_pkg.sv
// Shared constants, FSM encoding and index-width helper for the multi-precision
// add/subtract sequencer.
package csa_seq_pkg;

  localparam int WORD_W_DEF    = 16;
  localparam int NUM_WORDS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Never returns 0, so a one-word build still gets a 1-bit index register.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/csa_mp_sequencer_if.sv
// Operand/result handshake bundle between the ALU operand registers and the
// multi-precision sequencer.
interface csa_mp_sequencer_if #(
  parameter int OP_W = 64
);
  logic            start;
  logic            sub;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            cin;
  logic            busy;
  logic            done;
  logic [OP_W-1:0] result;
  logic            cout;
  logic            overflow;

  modport master (
    output start, sub, op_a, op_b, cin,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, cin,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/csa_adder_slice.sv
// Combinational WORD_W-bit carry-select adder: ripple low half, upper half
// precomputed for both carries and selected by the low-half carry-out.
module csa_adder_slice #(
  parameter int WORD_W = 16
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);
  localparam int LO_W = WORD_W / 2;
  localparam int HI_W = WORD_W - LO_W;

  logic [LO_W:0] lo;
  logic [HI_W:0] hi0;
  logic [HI_W:0] hi1;

  assign lo  = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]} + {{LO_W{1'b0}}, cin};
  assign hi0 = {1'b0, a[WORD_W-1:LO_W]} + {1'b0, b[WORD_W-1:LO_W]};
  assign hi1 = {1'b0, a[WORD_W-1:LO_W]} + {1'b0, b[WORD_W-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};

  assign sum[LO_W-1:0]             = lo[LO_W-1:0];
  assign {cout, sum[WORD_W-1:LO_W]} = lo[LO_W] ? hi1 : hi0;
endmodule

// File: rtl/csa_mp_sequencer.sv
// Sequences one shared carry-select slice over NUM_WORDS words, LSW first.
// Optional build macro: CSA_SEQ_EARLY_EXIT_EN (stop once upper words are zero).
module csa_mp_sequencer
  import csa_seq_pkg::*;
#(
  parameter int WORD_W    = WORD_W_DEF,
  parameter int NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  csa_mp_sequencer_if.slave   bus
);
  localparam int OP_W  = WORD_W * NUM_WORDS;
  localparam int IDX_W = clog2(NUM_WORDS);

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              carry_reg;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   b_reg;
  logic [OP_W-1:0]   result_reg;
  logic              cout_reg;
  logic              overflow_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [WORD_W-1:0] a_word;
  logic [WORD_W-1:0] b_word;
  logic [WORD_W-1:0] slice_sum;
  logic              slice_cout;
  logic              last_word;
  logic              early_exit;

  assign a_word    = a_reg[int'(idx_reg) * WORD_W +: WORD_W];
  assign b_word    = b_reg[int'(idx_reg) * WORD_W +: WORD_W];
  assign last_word = (idx_reg == IDX_W'(NUM_WORDS - 1));

  csa_adder_slice #(.WORD_W(WORD_W)) u_slice (
    .a    (a_word),
    .b    (b_word),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

`ifdef CSA_SEQ_EARLY_EXIT_EN
  logic                 sub_reg;
  logic [NUM_WORDS-1:0] word_nz;

  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word_nz
    assign word_nz[gi] = |{a_reg[gi*WORD_W +: WORD_W], b_reg[gi*WORD_W +: WORD_W]};
  end

  // Only words strictly above the current index matter.
  assign early_exit = !sub_reg && !slice_cout && (((word_nz >> idx_reg) >> 1) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      sub_reg <= 1'b0;
    else if (state_reg == IDLE && bus.start)
      sub_reg <= bus.sub;
  end
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      carry_reg    <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      cout_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg        <= bus.op_a;
            b_reg        <= bus.sub ? ~bus.op_b : bus.op_b;
            carry_reg    <= bus.sub ? 1'b1 : bus.cin;
            result_reg   <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            idx_reg      <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          result_reg[int'(idx_reg) * WORD_W +: WORD_W] <= slice_sum;
          carry_reg <= slice_cout;
          if (last_word || early_exit) begin
            cout_reg     <= slice_cout;
            // An early exit leaves zero upper words, so no signed overflow.
            overflow_reg <= last_word &&
                            (a_reg[OP_W-1] == b_reg[OP_W-1]) &&
                            (slice_sum[WORD_W-1] != a_reg[OP_W-1]);
            busy_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.result   = result_reg;
  assign bus.cout     = cout_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_csa_mp_sequencer.sv
// Directed-vector bench for csa_mp_sequencer (default 16x4 configuration).
module tb_csa_mp_sequencer;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  csa_mp_sequencer_if #(.OP_W(64)) bus ();

  csa_mp_sequencer #(.WORD_W(16), .NUM_WORDS(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one operation, wait (bounded) for done and check the outcome.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s, input int exp_lat,
                        input logic [63:0] exp_res, input logic exp_cout, input logic exp_ovf);
    int lat;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = c;
    bus.sub   = s;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.op_a  = ~a;
    bus.op_b  = ~b;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    $display("op %s a=%h b=%h cin=%0d sub=%0d -> result=%h cout=%0d ovf=%0d lat=%0d",
             tag, a, b, c, s, bus.result, bus.cout, bus.overflow, lat);
  endtask

`ifdef CSA_SEQ_EARLY_EXIT_EN
  localparam int LAT_INC = 2;
  localparam int LAT_SMALL = 1;
`else
  localparam int LAT_INC = 4;
  localparam int LAT_SMALL = 4;
`endif

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.cin   = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", {62'd0, bus.busy, bus.done}, 64'd0);
    end
    $display("reset/idle done");

    run_op("inc", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, LAT_INC,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 4,
           64'd0, 1'b1, 1'b0);
    run_op("sub0m1", 64'd0, 64'd1, 1'b1, 1'b1, 4,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("subovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 4,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Start pulses during RUN and DONE must be ignored.
    bus.op_a  = 64'h1234_5678_9ABC_DEF0;
    bus.op_b  = 64'h1111_1111_1111_1111;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.op_a  = 64'hDEAD_BEEF_0000_0001;
    bus.op_b  = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("ign_done", 64'(bus.done), 64'd1);
    check("ign_result", bus.result, 64'h2345_6789_ABCD_F001);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("ign_done_drop", 64'(bus.done), 64'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ign_quiet", {62'd0, bus.busy, bus.done}, 64'd0);
    end
    check("ign_result_hold", bus.result, 64'h2345_6789_ABCD_F001);
    $display("op ignored-start result=%h", bus.result);

    // Asynchronous reset between RUN edges 2 and 3.
    bus.op_a  = 64'h0001_0001_0001_0001;
    bus.op_b  = 64'h0001_0001_0001_0001;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("mid_partial", bus.result, 64'h0000_0000_0002_0002);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    check("mid_result", bus.result, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("mid_idle", {62'd0, bus.busy, bus.done}, 64'd0);
    $display("op async-reset mid-run result=%h", bus.result);

    run_op("after_rst", 64'd5, 64'd7, 1'b0, 1'b0, LAT_SMALL, 64'd12, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
